// File: rtl/s2axi_ring_writer.sv
// Stream-to-AXI3 ring writer: buffers a valid/ready stream in a FIFO and writes fixed-length INCR
// bursts into a DDR ring [base, base+size), reporting ring offset, committed bytes and error counts.
module s2axi_ring_writer #(
  parameter int unsigned DW         = 32,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned DROP_MODE  = 0,
  parameter logic [5:0]  AXI_ID     = 6'h3F
) (
  input  logic            AXI_clk,
  input  logic            rst,
  input  logic            sync,
  input  logic            enable,
  input  logic [31:0]     base,
  input  logic [31:0]     size,
  input  logic [DW-1:0]   s_data,
  input  logic            s_valid,
  output logic            s_ready,
  output logic [31:0]     AXI_awaddr,
  output logic            AXI_awvalid,
  output logic [3:0]      AXI_awlen,
  output logic [2:0]      AXI_awsize,
  output logic [1:0]      AXI_awburst,
  output logic [5:0]      AXI_awid,
  output logic [3:0]      AXI_awcache,
  output logic [2:0]      AXI_awprot,
  output logic [3:0]      AXI_awqos,
  output logic [1:0]      AXI_awlock,
  input  logic            AXI_awready,
  output logic [DW-1:0]   AXI_wdata,
  output logic            AXI_wvalid,
  output logic            AXI_wlast,
  output logic [DW/8-1:0] AXI_wstrb,
  output logic [5:0]      AXI_wid,
  input  logic            AXI_wready,
  input  logic            AXI_bvalid,
  input  logic [1:0]      AXI_bresp,
  input  logic [5:0]      AXI_bid,
  output logic            AXI_bready,
  output logic [31:0]     acnt,
  output logic [31:0]     bcnt,
  output logic [15:0]     err_cnt,
  output logic [15:0]     drop_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DepthC     = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] BurstC     = CW'(BURST_LEN);
  localparam logic [4:0]    LastBeat   = 5'(BURST_LEN - 1);
  localparam logic [31:0]   BurstBytes = 32'(BURST_LEN * DW / 8);

  typedef enum logic [1:0] {StIdle, StAw, StW, StB} state_e;

  state_e          state_q, state_d;
  logic [4:0]      beat_q, beat_d;
  logic [31:0]     awaddr_q, awaddr_d;
  logic [31:0]     size_q, size_d;
  logic [31:0]     acnt_q, acnt_d;
  logic [31:0]     bcnt_q, bcnt_d;
  logic [15:0]     err_q, err_d;
  logic [15:0]     drop_q;
  logic            sync_pend_q, sync_pend_d;

  logic [DW-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            full, push, pop, flush, drop;

  logic            unused_bid;
  assign unused_bid = ^AXI_bid;

  assign full = (count_q == DepthC);

  // Drop mode accepts into a full FIFO only when a pop frees the slot on the same edge.
  always_comb begin
    push = 1'b0;
    drop = 1'b0;
    if (DROP_MODE != 0) begin
      push = s_valid && (!full || pop);
      drop = s_valid && full && !pop;
    end else begin
      push = s_valid && !full;
    end
  end

  assign s_ready = (DROP_MODE != 0) ? 1'b1 : !full;

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    awaddr_d    = awaddr_q;
    size_d      = size_q;
    acnt_d      = acnt_q;
    bcnt_d      = bcnt_q;
    err_d       = err_q;
    sync_pend_d = sync_pend_q;
    flush       = 1'b0;
    AXI_awvalid = 1'b0;
    AXI_wvalid  = 1'b0;
    AXI_bready  = 1'b0;
    if (sync && state_q != StIdle) sync_pend_d = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (sync || sync_pend_q) begin
          flush       = 1'b1;
          acnt_d      = '0;
          sync_pend_d = 1'b0;
        end else if (enable && count_q >= BurstC) begin
          state_d  = StAw;
          awaddr_d = base + acnt_q;
          size_d   = size;
        end
      end
      StAw: begin
        AXI_awvalid = 1'b1;
        if (AXI_awready) begin
          state_d = StW;
          beat_d  = '0;
        end
      end
      StW: begin
        AXI_wvalid = 1'b1;
        if (AXI_wready) begin
          if (beat_q == LastBeat) state_d = StB;
          else                    beat_d  = beat_q + 5'd1;
        end
      end
      StB: begin
        AXI_bready = 1'b1;
        if (AXI_bvalid) begin
          if (AXI_bresp == 2'b00)  bcnt_d = bcnt_q + BurstBytes;
          else if (err_q != '1)    err_d  = err_q + 16'd1;
          acnt_d  = (acnt_q + BurstBytes == size_q) ? '0 : acnt_q + BurstBytes;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign pop = AXI_wvalid && AXI_wready;

  always_ff @(posedge AXI_clk) begin
    if (rst) begin
      state_q     <= StIdle;
      beat_q      <= '0;
      awaddr_q    <= '0;
      size_q      <= '0;
      acnt_q      <= '0;
      bcnt_q      <= '0;
      err_q       <= '0;
      sync_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      awaddr_q    <= awaddr_d;
      size_q      <= size_d;
      acnt_q      <= acnt_d;
      bcnt_q      <= bcnt_d;
      err_q       <= err_d;
      sync_pend_q <= sync_pend_d;
    end
  end

  always_ff @(posedge AXI_clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge AXI_clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= s_data;
  end

  always_ff @(posedge AXI_clk) begin
    if (rst) begin
      drop_q <= '0;
    end else if (drop && drop_q != 16'hFFFF) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign AXI_awaddr  = awaddr_q;
  assign AXI_awlen   = 4'(BURST_LEN - 1);
  assign AXI_awsize  = (DW == 64) ? 3'd3 : 3'd2;
  assign AXI_awburst = 2'b01;
  assign AXI_awid    = AXI_ID;
  assign AXI_awcache = '0;
  assign AXI_awprot  = '0;
  assign AXI_awqos   = '0;
  assign AXI_awlock  = '0;
  assign AXI_wdata   = mem_q[rd_ptr_q];
  assign AXI_wlast   = (state_q == StW) && (beat_q == LastBeat);
  assign AXI_wstrb   = '1;
  assign AXI_wid     = AXI_ID;
  assign acnt        = acnt_q;
  assign bcnt        = bcnt_q;
  assign err_cnt     = err_q;
  assign drop_cnt    = drop_q;

endmodule
